// File: rtl/fifo_wr_ingress_pkg.sv
// Shared definitions for the FIFO write-side ingress stage: default widths,
// the skid-buffer occupancy type and a saturating counter helper.
package fifo_wr_ingress_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Skid buffer occupancy, legal values 0..2.
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order storage with head/tail pointers. The caller guarantees
// that push only happens when there is room (occ<2, or occ=2 with a pop in
// the same cycle) and that pop only happens when occ!=0.
module skid_buf2
  import fifo_wr_ingress_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             push,
  input  logic             pop,
  input  logic [DSIZE-1:0] din,
  output logic [DSIZE-1:0] head,
  output occ_t             occ
);

  logic [DSIZE-1:0] mem [2];
  logic             hp;
  logic             tp;

  // Storage and pointer update. When full, push+pop writes the slot being
  // popped this same edge, so order is preserved without a bypass path.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      hp     <= 1'b0;
      tp     <= 1'b0;
      occ    <= OCC_EMPTY;
    end else begin
      if (push) begin
        mem[tp] <= din;
        tp      <= ~tp;
      end
      if (pop) begin
        hp <= ~hp;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Head word, forced to zero when nothing is buffered.
  always_comb begin
    head = '0;
    if (occ != OCC_EMPTY) begin
      head = mem[hp];
    end
  end

endmodule

// File: rtl/fifo_wr_ingress.sv
// Write-domain ingress in front of the async FIFO write pointer/memory.
//
// Handshake: a producer word transfers on every wclk edge where
// s_valid=1 and s_ready=1; s_valid/s_data are held stable by the producer
// until that happens. s_ready is a flop. On the FIFO side a word is written
// on every edge where winc=1; winc is never high while wfull=1.
//
// With drop_en=1, s_ready is held high and words arriving while the skid
// buffer is full and not draining are counted in drop_cnt and discarded.
module fifo_wr_ingress
  import fifo_wr_ingress_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  output logic             s_ready,
  input  logic             drop_en,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  occ_t             occ;
  occ_t             occ_next;
  logic [DSIZE-1:0] head;
  logic             push;
  logic             store;
  logic             drop;

  skid_buf2 #(.DSIZE(DSIZE)) u_skid (
    .wclk (wclk),
    .wrst (wrst),
    .push (store),
    .pop  (winc),
    .din  (s_data),
    .head (head),
    .occ  (occ)
  );

  // Pop, push/drop decisions and the occupancy after this edge. A full
  // buffer that drains this cycle still takes the incoming word.
  always_comb begin
    winc     = (occ != OCC_EMPTY) & ~wfull;
    wdata    = head;
    busy     = (occ != OCC_EMPTY);
    push     = s_valid & s_ready;
    store    = push & ((occ != OCC_FULL) | winc);
    drop     = push & (occ == OCC_FULL) & ~winc;
    occ_next = occ;
    case ({store, winc})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Registered ready: always open in drop mode, otherwise open while room remains.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      s_ready <= 1'b0;
    end else begin
      s_ready <= drop_en | (occ_next != OCC_FULL);
    end
  end

  // Write (wrapping) and drop (saturating) statistics.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wr_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (winc) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (drop) begin
        drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ingress.sv
// Self-checking bench for fifo_wr_ingress with a queue-based reference model.
module tb_fifo_wr_ingress;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       drop_en = 1'b0;
  logic       wfull = 1'b0;
  logic       winc;
  logic [7:0] wdata;
  logic [7:0] wr_cnt;
  logic [7:0] drop_cnt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic       m_ready;
  logic [7:0] m_wr;
  logic [7:0] m_drop;
  logic       last_acc;

  logic [26:0] obs_vec;
  assign obs_vec = {s_ready, winc, wdata, busy, wr_cnt, drop_cnt};

  // clock / reset
  always #5 wclk = ~wclk;

  fifo_wr_ingress #(.DSIZE(8), .CNT_W(8)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .drop_en  (drop_en),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .wr_cnt   (wr_cnt),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  function automatic logic [26:0] exp_vec();
    logic       we;
    logic [7:0] wd;
    we = (m_q.size() != 0) && !wfull;
    wd = (m_q.size() != 0) ? m_q[0] : 8'h00;
    return {m_ready, we, wd, (m_q.size() != 0), m_wr, m_drop};
  endfunction

  task automatic reset_model();
    m_q.delete();
    exp_q.delete();
    m_ready = 1'b0;
    m_wr    = 8'h00;
    m_drop  = 8'h00;
  endtask

  // driver: apply inputs for one cycle and advance the model at the edge
  task automatic tick(input logic v, input logic [7:0] d, input logic wf, input logic de);
    s_valid  = v;
    s_data   = d;
    wfull    = wf;
    drop_en  = de;
    last_acc = v && m_ready;
    @(posedge wclk);
    if (m_q.size() != 0 && !wf) begin
      void'(m_q.pop_front());
      m_wr = m_wr + 8'd1;
    end
    if (last_acc) begin
      if (m_q.size() < 2) begin
        m_q.push_back(d);
        exp_q.push_back(d);
      end else if (m_drop != 8'hFF) begin
        m_drop = m_drop + 8'd1;
      end
    end
    m_ready = de ? 1'b1 : (m_q.size() < 2);
    #1;
  endtask

  task automatic do_reset();
    wrst    = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    wfull   = 1'b0;
    drop_en = 1'b0;
    reset_model();
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // scoreboard: every FIFO write must be the next expected word
  always @(negedge wclk) begin
    logic [7:0] e;
    if (wrst === 1'b0 && winc === 1'b1) begin
      checks++;
      if (wfull !== 1'b0) begin
        failures++;
        $display("FAIL sb_winc_full: winc=1 while wfull=%b", wfull);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: wdata=%h written, none expected", wdata);
      end else begin
        e = exp_q.pop_front();
        if (wdata !== e) begin
          failures++;
          $display("FAIL sb_order: wdata=%h expected=%h", wdata, e);
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if (obs_vec !== 27'd0) begin
      failures++;
      $display("FAIL reset_state: obs=%h expected=0", obs_vec);
    end
    reset_model();
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early: s_ready=%b expected=0", s_ready);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (s_ready !== 1'b1 || obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_ready_rise: s_ready=%b obs=%h expected=%h", s_ready, obs_vec, exp_vec());
    end
  endtask

  task automatic test_stream();
    logic [7:0] w;
    for (int i = 0; i < 3; i++) begin
      w = 8'h11 * 8'(i + 1);
      tick(1'b1, w, 1'b0, 1'b0);
      checks++;
      if (winc !== 1'b1 || wdata !== w || obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL stream_%0d: winc=%b wdata=%h obs=%h expected=%h", i, winc, wdata, obs_vec, exp_vec());
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (winc !== 1'b0 || wr_cnt !== 8'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: winc=%b wr_cnt=%0d busy=%b expected 0/3/0", winc, wr_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [3];
    int idx;
    logic wf;
    words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
    do_reset();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      wf = (c < 5);
      if (idx < 3) tick(1'b1, words[idx], wf, 1'b0);
      else         tick(1'b0, 8'h00, wf, 1'b0);
      if (last_acc) idx++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL bp_cycle_%0d: obs=%h expected=%h", c, obs_vec, exp_vec());
      end
      if (c == 4) begin
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b1 || winc !== 1'b0 || idx != 2) begin
          failures++;
          $display("FAIL bp_held: s_ready=%b busy=%b winc=%b accepted=%0d expected 0/1/0/2", s_ready, busy, winc, idx);
        end
      end
    end
    checks++;
    if (idx != 3 || wr_cnt !== 8'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: accepted=%0d wr_cnt=%0d pending=%0d expected 3/3/0", idx, wr_cnt, exp_q.size());
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'hB1 + 8'(i), 1'b1, 1'b1);
    end
    checks++;
    if (drop_cnt !== 8'd3 || busy !== 1'b1 || s_ready !== 1'b1 || obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL drop_count: drop_cnt=%0d busy=%b s_ready=%b expected 3/1/1", drop_cnt, busy, s_ready);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (wr_cnt !== 8'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_drain: wr_cnt=%0d busy=%b expected 2/0", wr_cnt, busy);
    end
  endtask

  task automatic test_pop_push();
    do_reset();
    tick(1'b1, 8'hC1, 1'b1, 1'b1);
    tick(1'b1, 8'hC2, 1'b1, 1'b1);
    tick(1'b1, 8'hC3, 1'b0, 1'b1);
    checks++;
    if (drop_cnt !== 8'd0 || busy !== 1'b1 || wdata !== 8'hC2 || wr_cnt !== 8'd1 ||
        m_q.size() != 2 || obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL pop_push: drop_cnt=%0d wdata=%h wr_cnt=%0d expected 0/c2/1", drop_cnt, wdata, wr_cnt);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (wr_cnt !== 8'd3 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL pop_push_drain: wr_cnt=%0d busy=%b expected 3/0", wr_cnt, busy);
    end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      tick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (i == 255) begin
        checks++;
        if (wr_cnt !== 8'hFF) begin
          failures++;
          $display("FAIL wrap_ff: wr_cnt=%h expected=ff", wr_cnt);
        end
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (wr_cnt !== 8'h00 || obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL wrap_00: wr_cnt=%h expected=00", wr_cnt);
    end
    for (int i = 0; i < 302; i++) begin
      tick(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
      if (i == 255) begin
        checks++;
        if (drop_cnt !== 8'hFE) begin
          failures++;
          $display("FAIL sat_fe: drop_cnt=%h expected=fe", drop_cnt);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'hFF || obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL sat_ff: drop_cnt=%h expected=ff obs=%h model=%h", drop_cnt, obs_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 8'hD0, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 8'hD1, 1'b1, 1'b1);
    tick(1'b1, 8'hD2, 1'b1, 1'b1);
    tick(1'b1, 8'hD3, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || wr_cnt !== 8'd1 || drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL arst_pre: busy=%b wr_cnt=%0d drop_cnt=%0d expected 1/1/1", busy, wr_cnt, drop_cnt);
    end
    s_valid = 1'b0;
    wfull   = 1'b0;
    #1;
    wrst = 1'b1;
    reset_model();
    #1;
    checks++;
    if (winc !== 1'b0 || busy !== 1'b0 || wr_cnt !== 8'd0 || drop_cnt !== 8'd0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL arst_now: winc=%b busy=%b wr_cnt=%0d drop_cnt=%0d s_ready=%b expected all 0",
               winc, busy, wr_cnt, drop_cnt, s_ready);
    end
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (winc !== 1'b0 || obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL arst_after_%0d: winc=%b obs=%h expected=%h", i, winc, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic de;
    do_reset();
    de = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 40) == 0) de = ~de;
      tick($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0, de);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_%0d: obs=%h expected=%h", c, obs_vec, exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || wr_cnt !== m_wr) begin
      failures++;
      $display("FAIL random_drain: pending=%0d busy=%b wr_cnt=%0d expected 0/0/%0d", exp_q.size(), busy, wr_cnt, m_wr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_pop_push();
    test_wrap_sat();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
